// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multicycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (logic, shifts, add/sub, compares, divide-by-zero) finish
// one cycle after accept. MUL/MULHU use an iterative shift-add unit and
// DIVU/REMU use a restoring divider, one step per BUSY cycle.
// Only one operation is in flight at a time. The result and flags are held
// until the consumer takes them.
//
// Optional feature macro: ALU_MC_EARLY_MUL_EN
//   When defined, a multiply ends as soon as the remaining multiplier bits
//   are all zero. When undefined, a multiply always takes WIDTH BUSY cycles.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operation handshake (ALUOP, port_a, port_b)
//   out_valid/ out_ready result handshake (port_out + flags)
//   negative, zero       taken from the registered result
//   overflow             signed overflow for ADD/SUB, high half != 0 for MUL
//   div_by_zero          DIVU/REMU issued with port_b == 0
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUOP,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] port_out,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator
    logic [2*WIDTH-1:0] mcand_q, mcand_d;    // multiplicand, shifted left per step
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier, consumed LSB first
    logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;        // dividend shifting out / quotient in
    logic [WIDTH-1:0]   dvs_q, dvs_d;        // divisor
    logic [WIDTH-1:0]   res_q, res_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    // ---------------- single-cycle result path ----------------
    logic [WIDTH-1:0] sum, diff, quick_res;
    logic             quick_ovf, quick_dbz, quick_flag_en, needs_iter;

    always_comb begin
        sum           = port_a + port_b;
        diff          = port_a - port_b;
        quick_res     = '0;
        quick_ovf     = 1'b0;
        quick_dbz     = 1'b0;
        quick_flag_en = 1'b1;
        needs_iter    = 1'b0;
        case (ALUOP)
            OP_SLL:  quick_res = port_a << port_b[SH_W-1:0];
            OP_SRL:  quick_res = port_a >> port_b[SH_W-1:0];
            OP_ADD: begin
                quick_res = sum;
                quick_ovf = (port_a[M] == port_b[M]) && (sum[M] != port_a[M]);
            end
            OP_SUB: begin
                quick_res = diff;
                quick_ovf = (port_a[M] != port_b[M]) && (diff[M] != port_a[M]);
            end
            OP_AND:  quick_res = port_a & port_b;
            OP_OR:   quick_res = port_a | port_b;
            OP_XOR:  quick_res = port_a ^ port_b;
            OP_NOR:  quick_res = ~(port_a | port_b);
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (port_a < port_b)};
            OP_MUL, OP_MULHU: needs_iter = 1'b1;
            OP_DIVU: begin
                if (port_b == '0) begin
                    quick_res = '1;
                    quick_dbz = 1'b1;
                end else begin
                    needs_iter = 1'b1;
                end
            end
            OP_REMU: begin
                if (port_b == '0) begin
                    quick_res = port_a;
                    quick_dbz = 1'b1;
                end else begin
                    needs_iter = 1'b1;
                end
            end
            default: quick_flag_en = 1'b0;  // reserved opcodes: result 0, all flags 0
        endcase
    end

    // ---------------- iterative step path ----------------
    logic               is_mul, last_step;
    logic [2*WIDTH-1:0] acc_step, mcand_step;
    logic [WIDTH-1:0]   mplier_step, rem_step, quo_step, iter_res;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               iter_ovf;

    always_comb begin
        is_mul      = (op_q == OP_MUL) || (op_q == OP_MULHU);
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_step  = mcand_q << 1;
        mplier_step = mplier_q >> 1;
        // Restoring divide: the borrow out of the trial subtraction tells
        // whether the shifted remainder was at least the divisor.
        rem_sh      = {rem_q, quo_q[M]};
        rem_sub     = rem_sh - {1'b0, dvs_q};
        rem_step    = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
        quo_step    = {quo_q[M-1:0], ~rem_sub[WIDTH]};
`ifdef ALU_MC_EARLY_MUL_EN
        last_step   = (cnt_q == CNT_W'(1)) || (is_mul && (mplier_step == '0));
`else
        last_step   = (cnt_q == CNT_W'(1));
`endif
        iter_ovf    = 1'b0;
        case (op_q)
            OP_MUL: begin
                iter_res = acc_step[WIDTH-1:0];
                iter_ovf = |acc_step[2*WIDTH-1:WIDTH];
            end
            OP_MULHU: iter_res = acc_step[2*WIDTH-1:WIDTH];
            OP_DIVU:  iter_res = quo_step;
            default:  iter_res = rem_step;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = ALUOP;
                    if (needs_iter) begin
                        state_d  = S_BUSY;
                        cnt_d    = CNT_W'(WIDTH);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, port_a};
                        mplier_d = port_b;
                        rem_d    = '0;
                        quo_d    = port_a;
                        dvs_d    = port_b;
                    end else begin
                        state_d = S_DONE;
                        res_d   = quick_res;
                        neg_d   = quick_flag_en & quick_res[M];
                        zero_d  = quick_flag_en & (quick_res == '0);
                        ovf_d   = quick_ovf;
                        dbz_d   = quick_dbz;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_mul) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_step;
                    mplier_d = mplier_step;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                end
                if (last_step) begin
                    state_d = S_DONE;
                    res_d   = iter_res;
                    neg_d   = iter_res[M];
                    zero_d  = (iter_res == '0);
                    ovf_d   = iter_ovf;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign port_out    = res_q;
    assign negative    = neg_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle ALU: successor to the single-cycle combinational ALU.
- Adds a valid/ready handshake on both sides, generic data width, and iterative multiply/divide units.
- Sits in the execute stage of each core. The pipeline stalls while in_ready or out_valid is low.
- One operation is in flight at a time. The result and flags are registered.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- ALUOP  input  4  operation code (encoding under Behaviour).
- port_a  input  WIDTH  operand A.
- port_b  input  WIDTH  operand B.
- out_valid  output  1  result registered and held.
- out_ready  input  1  consumer takes the result.
- port_out  output  WIDTH  result.
- negative  output  1  port_out[WIDTH-1].
- zero  output  1  port_out == 0.
- overflow  output  1  see Behaviour.
- div_by_zero  output  1  DIVU/REMU issued with port_b == 0.

Behaviour:
- Opcodes:
  - 0 SLL: a << b[log2 W-1:0].
  - 1 SRL: logical right shift.
  - 2 ADD, 3 SUB.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT: signed compare, result 1/0.
  - 9 SLTU: unsigned compare, result 1/0.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11 MULHU: high WIDTH bits of the unsigned product.
  - 12 DIVU: unsigned quotient.
  - 13 REMU: unsigned remainder.
  - 14, 15: result 0, all flags 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge latches ALUOP, port_a and port_b.
- Opcodes 0-9, 14, 15, and DIVU/REMU with b==0: IDLE→DONE. out_valid is high the cycle after accept (latency 1).
- Other opcodes 10-13: IDLE→BUSY, counter loaded with WIDTH.
  - Each BUSY cycle performs one shift-add (multiply) or one restoring-subtract step (divide); counter decrements by 1.
  - When the counter reaches 1, the step completes and the unit goes BUSY→DONE.
  - out_valid rises WIDTH+1 cycles after accept.
- DONE: port_out, the flags and div_by_zero hold stable until out_valid & out_ready, then DONE→IDLE.
  - No accept is possible in the same cycle as the release.
  - Back-to-back throughput is 1 op / 2 cycles for single-cycle ops.
- Divide by zero:
  - DIVU result is all ones; REMU result is port_a.
  - div_by_zero=1, overflow=0.
- overflow:
  - ADD/SUB: signed overflow.
  - MUL: high product half ≠ 0.
  - MULHU: 0.
  - All others: 0.
- Flags are computed from the final registered result. negative and zero are valid only while out_valid=1. All are held in DONE.
- Shift amount uses only the low $clog2(WIDTH) bits of b.
- in_valid while busy is ignored; the caller must hold it until in_ready.
- Reset (async, nRST low), any state:
  - State→IDLE, in_ready=1, out_valid=0.
  - port_out=0, all flags 0, counter 0.
  - An in-flight operation is discarded; no partial result is ever emitted.

Optional Feature:
- Macro ALU_MC_EARLY_MUL_EN.
- Defined:
  - MUL/MULHU consume multiplier bits LSB first, one per BUSY cycle.
  - After a step, if the remaining unshifted multiplier bits are all 0, the unit goes BUSY→DONE immediately.
  - BUSY cycles = max(1, index of highest set bit of b + 1).
  - Results are identical to the full iteration. Division is unaffected.
- Undefined: multiply always takes WIDTH BUSY cycles.

Test Plan:
- Reset mid-operation: issue MUL 7×9, assert nRST low during BUSY cycle 5 → next cycle in_ready=1, out_valid=0, port_out=0. Then ADD 1+1 → port_out=2, one cycle after accept.
- ADD 0x7FFFFFFF+1 (WIDTH=32) → port_out=0x80000000, overflow=1, negative=1, zero=0, latency 1. SUB 5−5 → zero=1, overflow=0.
- MUL 0x10000×0x10000 → port_out=0, overflow=1, out_valid 33 cycles after accept. MULHU with the same operands → 0x00000001.
- DIVU 100/7 → 14. REMU 100/7 → 2, latency 33. DIVU 5/0 → 0xFFFFFFFF, div_by_zero=1, latency 1.
- Backpressure: out_ready=0 for 10 cycles after SLT −1<1 → port_out=1 held stable and in_ready=0 throughout. Raising out_ready → IDLE next cycle.
- With ALU_MC_EARLY_MUL_EN: MUL 1000×3 → 3000 after 2 BUSY cycles (out_valid 3 cycles after accept). MUL 5×0 → 0 after 1 BUSY cycle.
